// File: rtl/rv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_pkg : RV32I opcodes, op-class and immediate-format encodings
// Rev 1.0
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam logic [6:0] c_LUI     = 7'b0110111;
  localparam logic [6:0] c_AUIPC   = 7'b0010111;
  localparam logic [6:0] c_JAL     = 7'b1101111;
  localparam logic [6:0] c_JALR    = 7'b1100111;
  localparam logic [6:0] c_BRANCH  = 7'b1100011;
  localparam logic [6:0] c_LOAD    = 7'b0000011;
  localparam logic [6:0] c_STORE   = 7'b0100011;
  localparam logic [6:0] c_OPIMM   = 7'b0010011;
  localparam logic [6:0] c_OP      = 7'b0110011;
  localparam logic [6:0] c_MISCMEM = 7'b0001111;
  localparam logic [6:0] c_SYSTEM  = 7'b1110011;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_LUI     = 4'd1,
    OP_AUIPC   = 4'd2,
    OP_JAL     = 4'd3,
    OP_JALR    = 4'd4,
    OP_BRANCH  = 4'd5,
    OP_LOAD    = 4'd6,
    OP_STORE   = 4'd7,
    OP_OPIMM   = 4'd8,
    OP_OP      = 4'd9,
    OP_FENCE   = 4'd10,
    OP_SYSTEM  = 4'd11,
    OP_ILLEGAL = 4'd12
  } op_e;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

endpackage
`default_nettype wire

// File: rtl/decode_stage_imm_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_gen : instruction word to sign-extended immediate and its format
// Rev 1.0
// ---------------------------------------------------------------------------
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm,
  output logic [2:0]  o_fmt
);

  imm_fmt_e w_fmt;

  always_comb begin
    w_fmt = FMT_NONE;
    case (i_instr[6:0])
      c_LUI, c_AUIPC:                     w_fmt = FMT_U;
      c_JAL:                              w_fmt = FMT_J;
      c_JALR, c_LOAD, c_OPIMM, c_MISCMEM: w_fmt = FMT_I;
      c_BRANCH:                           w_fmt = FMT_B;
      c_STORE:                            w_fmt = FMT_S;
      default:                            w_fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    o_imm = '0;
    case (w_fmt)
      FMT_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      FMT_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                      i_instr[11:8], 1'b0};
      FMT_U: o_imm = {i_instr[31:12], 12'b0};
      FMT_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                      i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

  assign o_fmt = w_fmt;

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_stage : RV32I decode, operand read with writeback bypass, ID/EX
//                register and load-use interlock
// Rev 1.0
// ---------------------------------------------------------------------------
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      ra_addr,
  output logic [4:0]      rb_addr,
  input  logic [XLEN-1:0] ra_data,
  input  logic [XLEN-1:0] rb_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_imm,
  output logic [3:0]      ex_op,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_illegal
);

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_BUBBLE = 1'b1
  } state_e;

  localparam logic [1:0] c_BUB_INIT = 2'(LOAD_USE_BUBBLES - 1);

  logic [6:0]      w_opc;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  op_e             w_op;
  logic            w_use1, w_use2, w_wr, w_illegal;
  logic            w_hazard, w_accept;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;
  logic [31:0]     w_imm;
  logic [2:0]      w_fmt;
  state_e          r_state, w_state_nxt;
  logic [1:0]      r_cnt, w_cnt_nxt;

  logic            r_valid;
  logic [XLEN-1:0] r_pc, r_rs1_val, r_rs2_val, r_imm;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  logic [3:0]      r_op;
  logic [2:0]      r_funct3;
  logic            r_funct7b5, r_illegal;

  assign w_opc   = if_instr[6:0];
  assign w_rs1   = if_instr[19:15];
  assign w_rs2   = if_instr[24:20];
  assign ra_addr = w_rs1;
  assign rb_addr = w_rs2;

  imm_gen u_imm_gen (
    .i_instr (if_instr),
    .o_imm   (w_imm),
    .o_fmt   (w_fmt)
  );

  always_comb begin
    w_op   = OP_ILLEGAL;
    w_use1 = 1'b0;
    w_wr   = 1'b0;
    if (if_instr[1:0] == 2'b11) begin
      case (w_opc)
        c_LUI:     begin w_op = OP_LUI;    w_wr = 1'b1; end
        c_AUIPC:   begin w_op = OP_AUIPC;  w_wr = 1'b1; end
        c_JAL:     begin w_op = OP_JAL;    w_wr = 1'b1; end
        c_JALR:    begin w_op = OP_JALR;   w_wr = 1'b1; w_use1 = 1'b1; end
        c_BRANCH:  begin w_op = OP_BRANCH;              w_use1 = 1'b1; end
        c_LOAD:    begin w_op = OP_LOAD;   w_wr = 1'b1; w_use1 = 1'b1; end
        c_STORE:   begin w_op = OP_STORE;               w_use1 = 1'b1; end
        c_OPIMM:   begin w_op = OP_OPIMM;  w_wr = 1'b1; w_use1 = 1'b1; end
        c_OP:      begin w_op = OP_OP;     w_wr = 1'b1; w_use1 = 1'b1; end
        c_MISCMEM: begin w_op = OP_FENCE;  end
        c_SYSTEM:  begin w_op = OP_SYSTEM; w_wr = 1'b1; end
        default:   begin w_op = OP_ILLEGAL; end
      endcase
    end
  end

  // Only STORE (S), BRANCH (B) and register-register ops read rs2.
  assign w_use2    = (w_fmt == FMT_S) || (w_fmt == FMT_B) || (w_op == OP_OP);
  assign w_illegal = (w_op == OP_ILLEGAL);
  assign w_rd      = w_wr ? if_instr[11:7] : 5'd0;

  // Regfile writes land on the edge, so the current write port is forwarded.
  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 :
                     (wb_en && (wb_addr == w_rs1)) ? wb_data : ra_data;
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 :
                     (wb_en && (wb_addr == w_rs2)) ? wb_data : rb_data;

  assign w_hazard = r_valid && (r_op == OP_LOAD) && (r_rd != 5'd0) &&
                    ((w_use1 && (w_rs1 == r_rd)) || (w_use2 && (w_rs2 == r_rd)));

  assign if_ready = !flush && (r_state == S_RUN) && !w_hazard && (!r_valid || ex_ready);
  assign w_accept = if_valid && if_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = S_RUN;
      w_cnt_nxt   = 2'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_hazard && ex_ready) begin
            w_state_nxt = S_BUBBLE;
            w_cnt_nxt   = c_BUB_INIT;
          end
        end
        S_BUBBLE: begin
          if (r_cnt == 2'd0) w_state_nxt = S_RUN;
          else               w_cnt_nxt   = r_cnt - 2'd1;
        end
        default: begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_val  <= '0;
      r_rs2_val  <= '0;
      r_imm      <= '0;
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_rd       <= 5'd0;
      r_op       <= OP_NOP;
      r_funct3   <= 3'd0;
      r_funct7b5 <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_pc       <= if_pc;
      r_rs1_val  <= w_rs1_val;
      r_rs2_val  <= w_rs2_val;
      r_imm      <= w_imm;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_op       <= w_op;
      r_funct3   <= if_instr[14:12];
      r_funct7b5 <= if_instr[30];
      r_illegal  <= w_illegal;
    end else if (ex_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_pc       = r_pc;
  assign ex_rs1_val  = r_rs1_val;
  assign ex_rs2_val  = r_rs2_val;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;
  assign ex_rd       = r_rd;
  assign ex_imm      = r_imm;
  assign ex_op       = r_op;
  assign ex_funct3   = r_funct3;
  assign ex_funct7b5 = r_funct7b5;
  assign ex_illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_decode_stage : decode table, hand-written pipeline sequences and random
//                   traffic checked against a transaction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_decode_stage;
  import rv_pkg::*;

  localparam int LUB = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  ra_addr, rb_addr;
  logic [31:0] ra_data, rb_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_op;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_illegal;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .LOAD_USE_BUBBLES(LUB)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_op(ex_op), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_illegal(ex_illegal)
  );

  // Regfile model; x0 deliberately reads garbage so the decoder must zero it.
  logic [31:0] regs [32];
  always @(posedge clk) if (wb_en && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
  assign ra_data = (ra_addr == 5'd0) ? 32'hBAD0_0000 : regs[ra_addr];
  assign rb_data = (rb_addr == 5'd0) ? 32'hBAD0_0000 : regs[rb_addr];

  typedef struct packed {
    logic [31:0] pc, a, b;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic        f7, ill;
  } exrec_t;

  int     vec = 0, errs = 0;
  logic   m_valid;
  exrec_t m_rec;
  int     m_bub;
  logic   s_ready, s_exv;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] oper(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (wb_en && wb_addr == rs) return wb_data;
    return regs[rs];
  endfunction

  function automatic exrec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exrec_t r;
    logic   wr;
    r = '0; wr = 1'b0;
    r.pc = pc; r.rs1 = ins[19:15]; r.rs2 = ins[24:20];
    r.f3 = ins[14:12]; r.f7 = ins[30];
    case (ins[6:0])
      7'b0110111: begin r.op = OP_LUI;    wr = 1; r.imm = {ins[31:12], 12'b0}; end
      7'b0010111: begin r.op = OP_AUIPC;  wr = 1; r.imm = {ins[31:12], 12'b0}; end
      7'b1101111: begin r.op = OP_JAL;    wr = 1;
        r.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
      7'b1100111: begin r.op = OP_JALR;   wr = 1; r.imm = {{20{ins[31]}}, ins[31:20]}; end
      7'b1100011: begin r.op = OP_BRANCH;
        r.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
      7'b0000011: begin r.op = OP_LOAD;   wr = 1; r.imm = {{20{ins[31]}}, ins[31:20]}; end
      7'b0100011: begin r.op = OP_STORE;
        r.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
      7'b0010011: begin r.op = OP_OPIMM;  wr = 1; r.imm = {{20{ins[31]}}, ins[31:20]}; end
      7'b0110011: begin r.op = OP_OP;     wr = 1; end
      7'b0001111: begin r.op = OP_FENCE;  r.imm = {{20{ins[31]}}, ins[31:20]}; end
      7'b1110011: begin r.op = OP_SYSTEM; wr = 1; end
      default:    begin r.op = OP_ILLEGAL; r.ill = 1'b1; end
    endcase
    r.rd = wr ? ins[11:7] : 5'd0;
    r.a  = oper(r.rs1);
    r.b  = oper(r.rs2);
    return r;
  endfunction

  function automatic logic uses1(input logic [3:0] op);
    return op inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP};
  endfunction
  function automatic logic uses2(input logic [3:0] op);
    return op inside {OP_BRANCH, OP_STORE, OP_OP};
  endfunction

  function automatic exrec_t dut_rec();
    exrec_t r;
    r.pc = ex_pc; r.a = ex_rs1_val; r.b = ex_rs2_val; r.rs1 = ex_rs1; r.rs2 = ex_rs2;
    r.rd = ex_rd; r.imm = ex_imm; r.op = ex_op; r.f3 = ex_funct3; r.f7 = ex_funct7b5;
    r.ill = ex_illegal;
    return r;
  endfunction

  // One clock: inputs are already driven (at a falling edge).
  task automatic step();
    exrec_t nx;
    logic   hz, rdy;
    #1;
    nx  = ref_decode(if_instr, if_pc);
    hz  = m_valid && m_rec.op == OP_LOAD && m_rec.rd != 5'd0 &&
          ((uses1(nx.op) && nx.rs1 == m_rec.rd) || (uses2(nx.op) && nx.rs2 == m_rec.rd));
    rdy = !flush && m_bub == 0 && !hz && (!m_valid || ex_ready);
    s_ready = if_ready;
    s_exv   = ex_valid;
    chk("if_ready", {255'd0, if_ready}, {255'd0, rdy});
    chk("rf_addr", {246'd0, ra_addr, rb_addr}, {246'd0, if_instr[19:15], if_instr[24:20]});
    if (flush) begin
      m_valid = 1'b0; m_bub = 0;
    end else if (m_bub > 0) begin
      m_bub--;
    end else if (hz && ex_ready) begin
      m_valid = 1'b0; m_bub = LUB;
    end else if (if_valid && rdy) begin
      m_valid = 1'b1; m_rec = nx;
    end else if (ex_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("ex_valid", {255'd0, ex_valid}, {255'd0, m_valid});
    if (m_valid) chk("ex_record", {104'd0, dut_rec()}, {104'd0, m_rec});
  endtask

  task automatic idle();
    if_valid = 1'b0; wb_en = 1'b0; flush = 1'b0;
    step();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    case ($urandom_range(0, 13))
      0:  ins[6:0] = c_LUI;
      1:  ins[6:0] = c_AUIPC;
      2:  ins[6:0] = c_JAL;
      3:  ins[6:0] = c_JALR;
      4:  ins[6:0] = c_BRANCH;
      5:  ins[6:0] = c_STORE;
      6:  ins[6:0] = c_OPIMM;
      7:  ins[6:0] = c_OP;
      8:  ins[6:0] = c_MISCMEM;
      9:  ins[6:0] = c_SYSTEM;
      10: ins[6:0] = c_OP;
      11: ;
      default: ins[6:0] = c_LOAD;
    endcase
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
    logic [31:0] a;
  } vec_t;

  vec_t tbl [12];
  int   nb;
  logic done;

  initial begin
    tbl[0]  = '{32'h00718293, 32'h00000007, OP_OPIMM,   5'd5,  1'b0, 32'd3};
    tbl[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, OP_BRANCH,  5'd0,  1'b0, 32'd0};
    tbl[2]  = '{32'h0080006F, 32'h00000008, OP_JAL,     5'd0,  1'b0, 32'd0};
    tbl[3]  = '{32'h00000000, 32'h00000000, OP_ILLEGAL, 5'd0,  1'b1, 32'd0};
    tbl[4]  = '{32'h12345537, 32'h12345000, OP_LUI,     5'd10, 1'b0, 32'd8};
    tbl[5]  = '{32'hFE612C23, 32'hFFFFFFF8, OP_STORE,   5'd0,  1'b0, 32'd2};
    tbl[6]  = '{32'h00001097, 32'h00001000, OP_AUIPC,   5'd1,  1'b0, 32'd0};
    tbl[7]  = '{32'hFFF180E7, 32'hFFFFFFFF, OP_JALR,    5'd1,  1'b0, 32'd3};
    tbl[8]  = '{32'h00000073, 32'h00000000, OP_SYSTEM,  5'd0,  1'b0, 32'd0};
    tbl[9]  = '{32'h0000028F, 32'h00000000, OP_FENCE,   5'd0,  1'b0, 32'd0};
    tbl[10] = '{32'h402184B3, 32'h00000000, OP_OP,      5'd9,  1'b0, 32'd3};
    tbl[11] = '{32'h00718290, 32'h00000000, OP_ILLEGAL, 5'd0,  1'b1, 32'd3};

    reset = 1'b1; if_valid = 0; if_instr = 0; if_pc = 0; wb_en = 0; wb_addr = 0;
    wb_data = 0; flush = 0; ex_ready = 1;
    m_valid = 0; m_rec = '0; m_bub = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", {104'd0, ex_valid, dut_rec()}, {104'd0, 1'b0, 151'd0});
    @(negedge clk);
    reset = 1'b0;

    for (int i = 1; i < 32; i++) begin
      wb_en = 1; wb_addr = 5'(i); wb_data = i;
      step();
    end
    wb_en = 0;

    for (int i = 0; i < 12; i++) begin
      if_valid = 1; if_instr = tbl[i].instr; if_pc = 32'h1000 + 32'(4 * i);
      step();
      chk($sformatf("table_%0d", i), {142'd0, ex_valid, ex_imm, ex_op, ex_rd, ex_illegal, ex_rs1_val},
          {142'd0, 1'b1, tbl[i].imm, tbl[i].op, tbl[i].rd, tbl[i].ill, tbl[i].a});
    end
    idle();

    if_valid = 1; if_instr = 32'h00420333; if_pc = 32'h2000;
    wb_en = 1; wb_addr = 5'd4; wb_data = 32'hDEADBEEF;
    step();
    chk("bypass_x4", {192'd0, ex_rs1_val, ex_rs2_val}, {192'd0, 32'hDEADBEEF, 32'hDEADBEEF});
    if_instr = 32'h00000333; wb_addr = 5'd0;
    step();
    chk("bypass_x0", {192'd0, ex_rs1_val, ex_rs2_val}, {192'd0, 64'd0});
    if_valid = 0; wb_addr = 5'd4; wb_data = 32'd4;
    step();
    idle();

    for (int pass = 0; pass < 2; pass++) begin
      if_valid = 1; if_instr = pass == 0 ? 32'h00012383 : 32'h00012003; if_pc = 32'h3000;
      step();
      if_instr = pass == 0 ? 32'h00138433 : 32'h00100433; if_pc = 32'h3004;
      nb = 0; done = 0;
      for (int k = 0; k < 8 && !done; k++) begin
        step();
        if (!s_ready && !s_exv) nb++;
        if (s_ready) done = 1;
      end
      chk(pass == 0 ? "loaduse_bubbles" : "loaduse_rd0", {254'd0, done, nb[0]},
          {254'd0, 1'b1, pass == 0 ? 1'b1 : 1'b0});
      chk("loaduse_issue", {224'd0, ex_pc}, {224'd0, 32'h3004});
      idle();
    end

    if_valid = 1; if_instr = 32'h00718293; if_pc = 32'h100;
    step();
    ex_ready = 0; if_instr = 32'h402184B3; if_pc = 32'h104;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_ready", {255'd0, s_ready}, 256'd0);
    end
    chk("stall_hold", {192'd0, ex_pc, ex_imm}, {192'd0, 32'h100, 32'd7});
    ex_ready = 1;
    step();
    chk("stall_release", {224'd0, ex_pc}, {224'd0, 32'h104});
    idle();

    if_valid = 1; if_instr = 32'h00012383; if_pc = 32'h400;
    step();
    if_instr = 32'h00138433; if_pc = 32'h404;
    step();
    flush = 1;
    step();
    chk("flush_valid", {255'd0, ex_valid}, 256'd0);
    flush = 0;
    step();
    chk("flush_accept", {255'd0, s_ready}, {255'd0, 1'b1});
    idle();

    if_valid = 1; if_instr = 32'h00718293; if_pc = 32'h500;
    step();
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {219'd0, ex_valid, ex_pc, ex_op}, {219'd0, 1'b0, 32'd0, OP_NOP});
    m_valid = 0; m_bub = 0;
    if_valid = 0;
    @(negedge clk);
    reset = 1'b0;
    idle();

    for (int n = 0; n < 400; n++) begin
      if_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 31) == 0);
      wb_en    = $urandom_range(0, 1) == 1;
      wb_addr  = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      if_instr = rand_instr();
      if_pc    = $urandom & 32'hFFFF_FFFC;
      step();
    end
    ex_ready = 1;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I instruction decode stage. Sits between fetch and execute, and directly drives the read ports of regfile.
- Accepts fetched instructions over a valid/ready handshake and extracts rs1/rs2/rd. Reads operands from regfile, with bypass from the write port. Generates immediates.
- Registers the result into the ID/EX pipeline register.
- Owns the load-use interlock, which inserts bubbles.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- LOAD_USE_BUBBLES, 1, bubbles inserted on a load-use hazard (1..3).

Ports:
- clk  in  1  clock; all state is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  decode accepts when if_valid && if_ready.
- if_instr  in  32  instruction word.
- if_pc  in  XLEN  PC of if_instr.
- ra_addr  out  5  regfile port A address = if_instr[19:15]; combinational.
- rb_addr  out  5  regfile port B address = if_instr[24:20]; combinational.
- ra_data  in  XLEN  regfile port A data (combinational read).
- rb_data  in  XLEN  regfile port B data.
- wb_en  in  1  writeback enable; the same net as regfile w_en.
- wb_addr  in  5  writeback address.
- wb_data  in  XLEN  writeback data.
- flush  in  1  synchronous pipeline flush.
- ex_valid  out  1  ID/EX register holds an instruction.
- ex_ready  in  1  execute accepts.
- ex_pc  out  XLEN  PC.
- ex_rs1_val  out  XLEN  operand 1.
- ex_rs2_val  out  XLEN  operand 2.
- ex_rs1  out  5  source register 1 index.
- ex_rs2  out  5  source register 2 index.
- ex_rd  out  5  destination register; forced to 0 when the instruction does not write.
- ex_imm  out  XLEN  sign-extended immediate.
- ex_op  out  4  op class (package enum).
- ex_funct3  out  3  funct3 field.
- ex_funct7b5  out  1  instr[30].
- ex_illegal  out  1  illegal encoding flag.

Behaviour:
- Reset (asynchronous): ex_valid=0; every ex_* data output=0; ex_op=OP_NOP; interlock state=RUN; bubble counter=0.
- Regfile writes take effect on the clock edge, so a same-cycle write is invisible to a read. Bypass rule: if wb_en && wb_addr==rs && rs!=0, the operand is wb_data; otherwise it is ra_data/rb_data.
- x0: the operand is forced to 0 when rs==0, regardless of regfile data or bypass.
- Pipeline rule: if_ready = !flush && state==RUN && !hazard && (!ex_valid || ex_ready).
- Latency: an accepted instruction appears on ex_* the next cycle.
- While ex_valid && !ex_ready, every ex_* output holds.
- hazard = ex_valid && ex_op==OP_LOAD && ex_rd!=0 && ((uses_rs1 && rs1==ex_rd) || (uses_rs2 && rs2==ex_rd)).
  - uses_rs1 holds for JALR, BRANCH, LOAD, STORE, OPIMM, OP.
  - uses_rs2 holds for BRANCH, STORE, OP.
- Interlock FSM:
  - RUN to BUBBLE: when hazard && ex_ready. The load is handed downstream, ex_valid becomes 0, and the counter loads LOAD_USE_BUBBLES-1.
  - BUBBLE: ex_valid=0 and nothing is accepted. The counter decrements each cycle; at 0 the FSM returns to RUN and the held instruction is accepted on its next valid/ready beat.
  - If hazard && !ex_ready, the FSM stays in RUN and stalls.
- Flush has priority over everything. The next cycle has ex_valid=0 and state=RUN with counter 0. No instruction is accepted in the flush cycle.
- Immediate formats:
  - I: instr[31:20].
  - S: {instr[31:25],instr[11:7]}.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - U: {instr[31:12],12'b0}.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - All immediates are sign-extended from bit 31.
  - R-type and SYSTEM produce imm=0.
- Illegal encoding: instr[1:0]!=2'b11 or an unknown opcode gives ex_illegal=1, ex_op=OP_ILLEGAL, ex_rd=0. The instruction is still passed downstream with ex_valid=1.
- rd is forced to 0 for BRANCH, STORE, FENCE and illegal instructions.

Decomposition:
- Package rv_pkg holds:
  - opcode localparams (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011, MISCMEM 0001111, SYSTEM 1110011);
  - the 4-bit op-class enum (OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_FENCE, OP_SYSTEM, OP_ILLEGAL);
  - the imm-format enum.
- Sub-module imm_gen: combinational instruction to {imm, format}. The remainder of the stage stays in decode_stage.

Test Plan:
- Preload x1..x31 with value i via regfile. Feed addi x5,x3,7 (0x00718293) -> next cycle ex_rs1_val=3, ex_imm=7, ex_rd=5, ex_op=OP_OPIMM, ex_valid=1.
- Feed add x6,x4,x4 in the same cycle as wb_en=1, wb_addr=4, wb_data=0xDEADBEEF -> both operands=0xDEADBEEF (bypass). Repeat with wb_addr=0 and rs=0 -> both operands=0.
- Feed lw x7,0(x2) then add x8,x7,x1 with ex_ready=1 -> one cycle with ex_valid=0 and if_ready=0, then the add issues. The same pair with rd=x0 -> no bubble.
- Hold ex_ready=0 for 3 cycles with ex_valid=1 -> if_ready=0 and all ex_* outputs stable; on release, the next instruction appears the following cycle.
- Feed beq (0xFE000EE3, imm=-4) and jal (0x0080006F, imm=8) -> ex_imm=0xFFFFFFFC and 0x00000008; ex_rd=0 for beq. Feed instr 0x00000000 -> ex_illegal=1.
- Assert flush during a load-use bubble, then assert reset mid-stream -> ex_valid=0 the next cycle (flush), and immediately on reset. After flush, the first if_valid is accepted within one cycle.
